// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared bus widths and owner encoding for the data RAM arbiter
package ram_arbiter_pkg;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  typedef enum logic {OWNER_M0 = 1'b0, OWNER_M1 = 1'b1} owner_e;
  function automatic owner_e other_owner(input owner_e o);
    return o == OWNER_M0 ? OWNER_M1 : OWNER_M0;
  endfunction
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational grant selector, lock burst first then round-robin
module ram_arb_pick import ram_arbiter_pkg::*; #(
  parameter int LOCK_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic             i_m0_req,
  input  logic             i_m1_req,
  input  logic             i_m1_lock,
  input  owner_e           i_last_owner,
  input  logic [CNT_W-1:0] i_lock_cnt,
  output logic             o_gnt0,
  output logic             o_gnt1
);
  logic w_lock_win;
  assign w_lock_win = i_m1_lock && i_last_owner == OWNER_M1 && i_lock_cnt < CNT_W'(LOCK_MAX);
  assign o_gnt1 = i_m1_req && (!i_m0_req || w_lock_win || other_owner(i_last_owner) == OWNER_M1);
  assign o_gnt0 = i_m0_req && !o_gnt1;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between core (M0) and debug (M1) masters
module ram_arbiter import ram_arbiter_pkg::*; #(
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int DATA_W   = BUS_DATA_W,
  parameter int LOCK_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              core_hold_o,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  owner_e           r_last_owner;
  owner_e           r_rd_owner;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_rd_pend;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_rd;
  ram_arb_pick #(.LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) u_pick (
    .i_m0_req    (m0_req),
    .i_m1_req    (m1_req),
    .i_m1_lock   (m1_lock),
    .i_last_owner(r_last_owner),
    .i_lock_cnt  (r_lock_cnt),
    .o_gnt0      (w_pick0),
    .o_gnt1      (w_pick1)
  );
  assign m0_gnt      = w_pick0 && !rst;
  assign m1_gnt      = w_pick1 && !rst;
  assign core_hold_o = m0_req && !m0_gnt;
  assign w_rd        = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
  always_comb begin
    ram_wr_en_o = m0_gnt ? m0_we    : m1_gnt ? m1_we    : 1'b0;
    ram_addr_o  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
    ram_wdata_o = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
  end
  // rst also masks a return still in flight from the cycle before reset
  assign m0_rvalid = r_rd_pend && !rst && r_rd_owner == OWNER_M0;
  assign m1_rvalid = r_rd_pend && !rst && r_rd_owner == OWNER_M1;
  assign m0_rdata  = m0_rvalid ? ram_rdata_i : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata_i : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= OWNER_M1;
      r_rd_owner   <= OWNER_M0;
      r_lock_cnt   <= '0;
      r_rd_pend    <= 1'b0;
    end else begin
      if (m0_gnt || m1_gnt) r_last_owner <= m1_gnt ? OWNER_M1 : OWNER_M0;
      r_lock_cnt <= (m0_gnt || !m1_lock) ? '0 :
                    (m1_gnt && m0_req && r_lock_cnt < CNT_W'(LOCK_MAX)) ? r_lock_cnt + CNT_W'(1) : r_lock_cnt;
      r_rd_pend <= w_rd;
      if (w_rd) r_rd_owner <= m1_gnt ? OWNER_M1 : OWNER_M0;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random stimulus against a rule-level arbiter model
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LM = 3;
  localparam int CW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, core_hold_o, ram_wr_en_o;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wdata_o, ram_rdata_i;
  logic [AW-1:0] ram_addr_o;
  int checks = 0;
  int errors = 0;
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .core_hold_o(core_hold_o),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
    .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );
  logic [DW-1:0] tb_mem    [logic [AW-1:0]];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
  endfunction
  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction
  always @(posedge clk) begin
    if (ram_wr_en_o) tb_mem[ram_addr_o] = ram_wdata_o;
    ram_rdata_i <= ram_rd(ram_addr_o);
  end
  int            m_last = 1;
  int            m_streak = 0;
  bit            m_pend = 1'b0;
  bit            m_pend_own = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  bit            e_g0 = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r,
                      input logic i0r, input logic i0w, input logic [AW-1:0] i0a, input logic [DW-1:0] i0d,
                      input logic i1r, input logic i1w, input logic [AW-1:0] i1a, input logic [DW-1:0] i1d,
                      input logic lk);
    bit g0, g1, rv0, rv1;
    @(negedge clk);
    rst = r; m1_lock = lk;
    m0_req = i0r; m0_we = i0w; m0_addr = i0a; m0_wdata = i0d;
    m1_req = i1r; m1_we = i1w; m1_addr = i1a; m1_wdata = i1d;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!r && i0r && i1r) begin
      g1 = (lk && m_last == 1 && m_streak < LM) || m_last == 0;
      g0 = !g1;
    end else if (!r) begin
      g0 = i0r; g1 = i1r;
    end
    rv0 = !r && m_pend && !m_pend_own;
    rv1 = !r && m_pend && m_pend_own;
    chk("m0_gnt", m0_gnt, g0);
    chk("m1_gnt", m1_gnt, g1);
    chk("core_hold", core_hold_o, i0r && !g0);
    chk("ram_we", ram_wr_en_o, (g0 && i0w) || (g1 && i1w));
    chk("ram_addr", ram_addr_o, g0 ? i0a : g1 ? i1a : '0);
    chk("ram_wdata", ram_wdata_o, g0 ? i0d : g1 ? i1d : '0);
    chk("m0_rvalid", m0_rvalid, rv0);
    chk("m0_rdata", m0_rdata, rv0 ? m_pend_data : '0);
    chk("m1_rvalid", m1_rvalid, rv1);
    chk("m1_rdata", m1_rdata, rv1 ? m_pend_data : '0);
    e_g0 = g0;
    if (r) begin
      m_last = 1; m_streak = 0; m_pend = 1'b0;
    end else begin
      if (g0 || !lk) m_streak = 0;
      else if (g1 && i0r && m_streak < LM) m_streak++;
      if (g0 || g1) m_last = g1 ? 1 : 0;
      m_pend = (g0 && !i0w) || (g1 && !i1w);
      if (g0 && i0w) model_mem[i0a] = i0d;
      if (g1 && i1w) model_mem[i1a] = i1d;
      if (m_pend) begin
        m_pend_own  = g1;
        m_pend_data = model_rd(g1 ? i1a : i0a);
      end
    end
  endtask
  initial begin
    logic          p0, w0, r1, w1, lk, rr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    step(1, 0,0,0,0, 0,0,0,0, 0);
    step(1, 1,0,32'h10,0, 1,0,32'h20,0, 0);
    step(0, 1,0,32'h10,0, 0,0,0,0, 0);
    chk("tp1_gnt", m0_gnt, 1);
    step(0, 0,0,0,0, 0,0,0,0, 0);
    chk("tp1_rvalid", m0_rvalid, 1);
    chk("tp1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("tp1_m1_rvalid", m1_rvalid, 0);
    step(0, 0,0,0,0, 1,0,32'h20,0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1,0,32'h30,0, 1,0,32'h34,0, 0);
      chk("alt_g0", m0_gnt, i % 2 == 0);
      chk("alt_hold", core_hold_o, i % 2 == 1);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1,0,32'h38,0, 1,0,32'h3C,0, 1);
      chk("lock_g1", m1_gnt, i != 3);
    end
    step(0, 0,0,0,0, 1,1,32'h40,32'h12345678, 0);
    step(0, 1,0,32'h40,0, 0,0,0,0, 0);
    chk("raw_gnt", m0_gnt, 1);
    step(0, 0,0,0,0, 0,0,0,0, 0);
    chk("raw_rdata", m0_rdata, 32'h12345678);
    step(0, 1,0,32'h10,0, 0,0,0,0, 0);
    chk("rst_rd_gnt", m0_gnt, 1);
    step(1, 0,0,0,0, 0,0,0,0, 0);
    chk("rst_no_rvalid", m0_rvalid, 0);
    step(1, 0,0,0,0, 0,0,0,0, 0);
    step(0, 1,0,32'h50,0, 1,0,32'h54,0, 0);
    chk("rst_first_m0", m0_gnt, 1);
    step(0, 1,0,32'h0,0, 0,0,0,0, 0);
    step(0, 1,0,32'h4,0, 0,0,0,0, 0);
    chk("b2b_rv0", m0_rvalid, 1);
    chk("b2b_d0", m0_rdata, init_val(32'h0));
    step(0, 1,0,32'h8,0, 0,0,0,0, 0);
    chk("b2b_rv1", m0_rvalid, 1);
    chk("b2b_d1", m0_rdata, init_val(32'h4));
    step(0, 0,0,0,0, 0,0,0,0, 0);
    chk("b2b_rv2", m0_rvalid, 1);
    chk("b2b_d2", m0_rdata, init_val(32'h8));
    p0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    for (int i = 0; i < 600; i++) begin
      rr = $urandom_range(0, 49) == 0;
      if (!p0) begin
        p0 = $urandom_range(0, 9) < 6;
        w0 = $urandom_range(0, 1) == 1;
        a0 = AW'($urandom_range(0, 15) * 4);
        d0 = DW'($urandom);
      end
      r1 = $urandom_range(0, 9) < 6;
      w1 = $urandom_range(0, 1) == 1;
      a1 = AW'($urandom_range(0, 15) * 4);
      d1 = DW'($urandom);
      lk = $urandom_range(0, 2) != 0;
      step(rr, p0, w0, a0, d0, r1, w1, a1, d1, lk);
      if (e_g0) p0 = 1'b0;
    end
    step(0, 0,0,0,0, 0,0,0,0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
